// File: rtl/apb_watchdog_slave_pkg.sv
// Shared constants and types for the APB watchdog completer.
package apb_wdt_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_LOAD   = 8'h01;
    localparam logic [7:0] ADDR_KICK   = 8'h02;
    localparam logic [7:0] ADDR_COUNT  = 8'h03;
    localparam logic [7:0] ADDR_STATUS = 8'h04;

    localparam logic [20:0] KICK_KEY = 21'h0A5A5;
    localparam logic [20:0] LOAD_RST = 21'h1FFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } xfer_state_e;

endpackage

// File: rtl/apb_watchdog_slave_counter.sv
// Watchdog down-counter with reload and expiry strobe.
// Optional tick prescaler enabled by WDT_PRESCALER_EN.
module wdt_counter
    import apb_wdt_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        en,
    input  logic        tick_en,
    input  logic        reload,
    input  logic [20:0] load_val,
    output logic [20:0] count,
    output logic        expire
);

    logic [20:0] count_q, count_d;
    logic        tick;

`ifdef WDT_PRESCALER_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    // Free-running; restarted so the first tick after a reload is a full period away.
    always_comb begin
        pre_d = pre_q - 1'b1;
        if (reload || (pre_q == '0)) pre_d = PRE_TOP;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) pre_q <= PRE_TOP;
        else        pre_q <= pre_d;
    end

    assign tick = tick_en && (pre_q == '0);
`else
    assign tick = tick_en;
    if (PRESCALE < 1) begin : g_prescale_unused
    end
`endif

    // A reload in the same cycle as a terminal tick suppresses the expiry.
    assign expire = en && tick && (count_q == '0) && !reload;

    always_comb begin
        count_d = count_q;
        if (reload)          count_d = load_val;
        else if (en && tick) count_d = (count_q == '0) ? load_val : count_q - 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) count_q <= LOAD_RST;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/apb_watchdog_slave.sv
// APB completer: wait-state transfer FSM, watchdog register file and read mux.
// Optional watchdog prescaler enabled by WDT_PRESCALER_EN.
//
// state | meaning
// IDLE  | no transfer in progress
// WAIT  | access phase seen, counting wait states
// DONE  | PREADY issued, waiting for PSEL or PENABLE to drop
module apb_watchdog_slave
    import apb_wdt_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int PRESCALE    = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic [7:0]  PADDR,
    input  logic        PWRITE,
    input  logic [20:0] PWDATA,
    output logic [20:0] PRDATA,
    output logic        PREADY,
    output logic        wdt_irq,
    output logic        wdt_rst_req
);

    xfer_state_e state_q, state_d;
    logic [2:0]  ws_q, ws_d;
    logic        ready_q, ready_d;
    logic [20:0] prdata_q, prdata_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [20:0] load_q, load_d;
    logic        to_q, to_d;
    logic        bad_q, bad_d;
    logic        rst_req_q, rst_req_d;

    logic [20:0] count, rdata;
    logic [1:0]  clr;
    logic        expire, reload, wr_en, kick_wr, kick_ok, ctrl_wr;

    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: if (PSEL && PENABLE) begin
                if (WAIT_STATES == 0) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    ws_d    = 3'(WAIT_STATES - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!(PSEL && PENABLE)) state_d = IDLE;
                else if (ws_q == 3'd0) begin
                    ready_d = 1'b1;
                    state_d = DONE;
                end else ws_d = ws_q - 1'b1;
            end
            DONE:    if (!PSEL || !PENABLE) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writes commit at the end of the PREADY cycle.
    assign wr_en   = ready_q && PSEL && PENABLE && PWRITE;
    assign ctrl_wr = wr_en && (PADDR == ADDR_CTRL);
    assign kick_wr = wr_en && (PADDR == ADDR_KICK);
    assign kick_ok = kick_wr && (PWDATA == KICK_KEY);
    assign reload  = kick_ok || (ctrl_wr && PWDATA[0] && !ctrl_q[0]);
    assign clr     = (wr_en && (PADDR == ADDR_STATUS)) ? PWDATA[1:0] : 2'b00;

    always_comb begin
        ctrl_d    = ctrl_wr ? PWDATA[1:0] : ctrl_q;
        load_d    = (wr_en && (PADDR == ADDR_LOAD)) ? PWDATA : load_q;
        to_d      = expire || (to_q && !clr[0]);
        bad_d     = (kick_wr && !kick_ok) || (bad_q && !clr[1]);
        rst_req_d = expire && ctrl_q[1];
    end

    always_comb begin
        case (PADDR)
            ADDR_CTRL:   rdata = {19'b0, ctrl_q};
            ADDR_LOAD:   rdata = load_q;
            ADDR_COUNT:  rdata = count;
            ADDR_STATUS: rdata = {19'b0, bad_q, to_q};
            default:     rdata = '0;
        endcase
        prdata_d = (ready_d && !PWRITE) ? rdata : '0;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            ws_q      <= 3'd0;
            ready_q   <= 1'b0;
            prdata_q  <= '0;
            ctrl_q    <= 2'b00;
            load_q    <= LOAD_RST;
            to_q      <= 1'b0;
            bad_q     <= 1'b0;
            rst_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ws_q      <= ws_d;
            ready_q   <= ready_d;
            prdata_q  <= prdata_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            to_q      <= to_d;
            bad_q     <= bad_d;
            rst_req_q <= rst_req_d;
        end
    end

    wdt_counter #(
        .PRESCALE (PRESCALE)
    ) u_counter (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .en       (ctrl_q[0]),
        .tick_en  (1'b1),
        .reload   (reload),
        .load_val (load_q),
        .count    (count),
        .expire   (expire)
    );

    assign PREADY      = ready_q;
    assign PRDATA      = prdata_q;
    assign wdt_irq     = to_q;
    assign wdt_rst_req = rst_req_q;

endmodule

// File: tb/tb_apb_watchdog_slave.sv
// Self-checking bench for apb_watchdog_slave (default build, no prescaler).
module tb_apb_watchdog_slave;
    import apb_wdt_pkg::*;

    localparam int WS = 2;

    logic        PCLK, PRESET, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [20:0] PWDATA, PRDATA;
    logic        PREADY, wdt_irq, wdt_rst_req;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pulses = 0;
    bit pulse_log [int];

    logic [20:0] last_rd;
    int          last_rc, last_lat;
    logic        last_after;

    apb_watchdog_slave #(.WAIT_STATES(WS), .PRESCALE(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .wdt_irq(wdt_irq), .wdt_rst_req(wdt_rst_req)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) begin
        pulse_log[cyc] = (wdt_rst_req === 1'b1);
        if (wdt_rst_req === 1'b1) pulses++;
    end

    // Reference: after a reload at the end of cycle c, COUNT walks L..0 and wraps,
    // so t ticks later it is L - t mod (L+1), with floor(t/(L+1)) expiries.
    function automatic logic [20:0] exp_count(input int l, input int t);
        exp_count = 21'(l - (t % (l + 1)));
    endfunction

    task automatic apb(input logic [7:0] a, input logic w, input logic [20:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        last_lat = -1; last_rd = '0; last_rc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                last_lat = k; last_rd = PRDATA; last_rc = cyc;
                break;
            end
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        last_after = PREADY;
        if (last_lat < 0) begin
            n_cmp++; n_err++;
            $display("FAIL apb_timeout addr=%h got no PREADY within 20 cycles", a);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [20:0] d);
        apb(a, 1'b1, d);
    endtask

    task automatic rd(input logic [7:0] a, output logic [20:0] v);
        apb(a, 1'b0, 21'h0);
        v = last_rd;
    endtask

    task automatic test_reset();
        logic [20:0] v;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
        n_cmp++; if (PRDATA !== 21'h0) begin n_err++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
        n_cmp++; if (wdt_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", wdt_irq); end
        n_cmp++; if (wdt_rst_req !== 1'b0) begin n_err++; $display("FAIL reset_rstreq got=%b exp=0", wdt_rst_req); end
        PRESET = 1'b0;
        rd(ADDR_COUNT, v);
        n_cmp++; if (v !== 21'h1FFFFF) begin n_err++; $display("FAIL reset_count got=%h exp=1fffff", v); end
        rd(ADDR_CTRL, v);
        n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL reset_ctrl got=%h exp=0", v); end
        rd(ADDR_LOAD, v);
        n_cmp++; if (v !== 21'h1FFFFF) begin n_err++; $display("FAIL reset_load got=%h exp=1fffff", v); end
        rd(ADDR_STATUS, v);
        n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL reset_status got=%h exp=0", v); end
    endtask

    task automatic test_wait_states();
        logic [20:0] v;
        wr(ADDR_LOAD, 21'h10);
        n_cmp++; if (last_lat != WS + 1) begin n_err++; $display("FAIL ws_latency got=%0d exp=%0d", last_lat, WS + 1); end
        n_cmp++; if (last_after !== 1'b0) begin n_err++; $display("FAIL ws_pready_width got=%b exp=0", last_after); end
        rd(ADDR_LOAD, v);
        n_cmp++; if (v !== 21'h10) begin n_err++; $display("FAIL ws_readback got=%h exp=10", v); end
        n_cmp++; if (last_lat != WS + 1) begin n_err++; $display("FAIL ws_read_latency got=%0d exp=%0d", last_lat, WS + 1); end
    endtask

    task automatic test_sticky_penable();
        int got, extra;
        logic [20:0] v;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = ADDR_LOAD; PWRITE = 1'b0; PWDATA = '0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        got = -1; v = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin got = k; v = PRDATA; break; end
        end
        n_cmp++; if (got != WS + 1) begin n_err++; $display("FAIL sticky_first got=%0d exp=%0d", got, WS + 1); end
        n_cmp++; if (v !== 21'h10) begin n_err++; $display("FAIL sticky_data got=%h exp=10", v); end
        extra = 0;
        repeat (8) begin @(negedge PCLK); if (PREADY !== 1'b0) extra++; end
        @(posedge PCLK); #1; PENABLE = 1'b0;
        @(posedge PCLK); #1; PSEL = 1'b0;
        repeat (3) begin @(negedge PCLK); if (PREADY !== 1'b0) extra++; end
        n_cmp++; if (extra != 0) begin n_err++; $display("FAIL sticky_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_regs_random();
        logic [20:0] v, ld;
        logic [7:0]  ua;
        logic [1:0]  cv;
        for (int it = 0; it < 8; it++) begin
            ld = 21'($urandom);
            ua = 8'($urandom_range(5, 255));
            cv = {1'($urandom_range(0, 1)), 1'b0};
            wr(ADDR_LOAD, ld);
            wr(ua, 21'($urandom));
            wr(ADDR_CTRL, {19'b0, cv});
            rd(ADDR_LOAD, v);
            n_cmp++; if (v !== ld) begin n_err++; $display("FAIL reg_load it=%0d got=%h exp=%h", it, v, ld); end
            rd(ua, v);
            n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL reg_unmapped addr=%h got=%h exp=0", ua, v); end
            rd(ADDR_KICK, v);
            n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL reg_kick_read got=%h exp=0", v); end
            rd(ADDR_CTRL, v);
            n_cmp++; if (v !== {19'b0, cv}) begin n_err++; $display("FAIL reg_ctrl got=%h exp=%h", v, cv); end
        end
        wr(ADDR_CTRL, 21'h0);
    endtask

    task automatic test_abort();
        int seen;
        logic [20:0] v;
        wr(ADDR_LOAD, 21'h0AAAA);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = ADDR_LOAD; PWRITE = 1'b1; PWDATA = 21'h15555;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        seen = 0;
        repeat (2) begin @(negedge PCLK); if (PREADY !== 1'b0) seen++; end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (5) begin @(negedge PCLK); if (PREADY !== 1'b0) seen++; end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_pready got=%0d exp=0", seen); end
        rd(ADDR_LOAD, v);
        n_cmp++; if (v !== 21'h0AAAA) begin n_err++; $display("FAIL abort_commit got=%h exp=0aaaa", v); end
    endtask

    task automatic test_expiry();
        int c1, c2, t, base, first_irq, first_pulse, npulse;
        logic [20:0] v;
        wr(ADDR_LOAD, 21'd5);
        wr(ADDR_STATUS, 21'h3);
        base = pulses;
        wr(ADDR_CTRL, 21'h3);
        c1 = last_rc;
        first_irq = -1; first_pulse = -1; npulse = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge PCLK);
            if (wdt_irq === 1'b1 && first_irq < 0) first_irq = cyc;
            if (wdt_rst_req === 1'b1) begin npulse++; if (first_pulse < 0) first_pulse = cyc; end
        end
        n_cmp++; if (first_irq != c1 + 7) begin n_err++; $display("FAIL exp_irq_time got=%0d exp=%0d", first_irq - c1, 7); end
        n_cmp++; if (first_pulse != c1 + 7) begin n_err++; $display("FAIL exp_pulse_time got=%0d exp=%0d", first_pulse - c1, 7); end
        n_cmp++; if (npulse != 1) begin n_err++; $display("FAIL exp_pulse_count got=%0d exp=1", npulse); end
        wr(ADDR_CTRL, 21'h0);
        c2 = last_rc;
        t = c2 - c1;
        rd(ADDR_COUNT, v);
        n_cmp++; if (v !== exp_count(5, t)) begin n_err++; $display("FAIL exp_count got=%h exp=%h", v, exp_count(5, t)); end
        n_cmp++; if (pulses - base != t / 6) begin n_err++; $display("FAIL exp_total_pulses got=%0d exp=%0d", pulses - base, t / 6); end
        wr(ADDR_STATUS, 21'h1);
        n_cmp++; if (wdt_irq !== 1'b0) begin n_err++; $display("FAIL exp_irq_clear got=%b exp=0", wdt_irq); end
    endtask

    task automatic test_kick();
        int c1, ck, c2, gap, l, base;
        logic [20:0] v;
        wr(ADDR_LOAD, 21'd100);
        wr(ADDR_STATUS, 21'h3);
        wr(ADDR_CTRL, 21'h1); c1 = last_rc;
        wr(ADDR_KICK, KICK_KEY); ck = last_rc;
        wr(ADDR_CTRL, 21'h0); c2 = last_rc;
        gap = ck - c1;
        rd(ADDR_COUNT, v);
        n_cmp++; if (v !== exp_count(100, c2 - ck)) begin n_err++; $display("FAIL kick_reload got=%h exp=%h", v, exp_count(100, c2 - ck)); end
        // COUNT during the kick's PREADY cycle is l-(gap-1); choose l so it is 2.
        l = gap + 1;
        wr(ADDR_LOAD, 21'(l));
        wr(ADDR_STATUS, 21'h3);
        base = pulses;
        wr(ADDR_CTRL, 21'h3); c1 = last_rc;
        wr(ADDR_KICK, KICK_KEY); ck = last_rc;
        wr(ADDR_CTRL, 21'h0); c2 = last_rc;
        rd(ADDR_COUNT, v);
        n_cmp++; if (v !== exp_count(l, c2 - ck)) begin n_err++; $display("FAIL kick_at2_count got=%h exp=%h", v, exp_count(l, c2 - ck)); end
        rd(ADDR_STATUS, v);
        n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL kick_at2_status got=%h exp=0", v); end
        n_cmp++; if (pulses != base) begin n_err++; $display("FAIL kick_at2_pulses got=%0d exp=0", pulses - base); end
    endtask

    task automatic test_badkick();
        int c1, c2;
        logic [20:0] v;
        wr(ADDR_LOAD, 21'd200);
        wr(ADDR_STATUS, 21'h3);
        wr(ADDR_CTRL, 21'h1); c1 = last_rc;
        wr(ADDR_KICK, 21'h00001);
        wr(ADDR_CTRL, 21'h0); c2 = last_rc;
        rd(ADDR_COUNT, v);
        n_cmp++; if (v !== exp_count(200, c2 - c1)) begin n_err++; $display("FAIL badkick_count got=%h exp=%h", v, exp_count(200, c2 - c1)); end
        rd(ADDR_STATUS, v);
        n_cmp++; if (v !== 21'h2) begin n_err++; $display("FAIL badkick_status got=%h exp=2", v); end
        wr(ADDR_STATUS, 21'h2);
        rd(ADDR_STATUS, v);
        n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL badkick_clear got=%h exp=0", v); end
    endtask

    task automatic test_kick_vs_expiry();
        int c1, ck;
        wr(ADDR_LOAD, 21'd0);
        wr(ADDR_STATUS, 21'h3);
        wr(ADDR_CTRL, 21'h3); c1 = last_rc;
        wr(ADDR_KICK, KICK_KEY); ck = last_rc;
        wr(ADDR_CTRL, 21'h0);
        n_cmp++; if (pulse_log[c1 + 2] !== 1'b1) begin n_err++; $display("FAIL load0_first got=%b exp=1", pulse_log[c1 + 2]); end
        n_cmp++; if (pulse_log[ck] !== 1'b1) begin n_err++; $display("FAIL load0_before_kick got=%b exp=1", pulse_log[ck]); end
        n_cmp++; if (pulse_log[ck + 1] !== 1'b0) begin n_err++; $display("FAIL kick_wins got=%b exp=0", pulse_log[ck + 1]); end
        n_cmp++; if (pulse_log[ck + 2] !== 1'b1) begin n_err++; $display("FAIL load0_after_kick got=%b exp=1", pulse_log[ck + 2]); end
        wr(ADDR_STATUS, 21'h3);
    endtask

    task automatic test_random_run();
        int l, rs, idle, c1, c2, t, nexp, base, ep;
        logic [20:0] v;
        for (int it = 0; it < 8; it++) begin
            l = $urandom_range(0, 30);
            rs = $urandom_range(0, 1);
            idle = $urandom_range(0, 80);
            wr(ADDR_LOAD, 21'(l));
            wr(ADDR_STATUS, 21'h3);
            base = pulses;
            wr(ADDR_CTRL, {19'b0, rs[0], 1'b1}); c1 = last_rc;
            repeat (idle) @(negedge PCLK);
            wr(ADDR_CTRL, 21'h0); c2 = last_rc;
            t = c2 - c1;
            nexp = t / (l + 1);
            ep = (rs != 0) ? nexp : 0;
            rd(ADDR_COUNT, v);
            n_cmp++; if (v !== exp_count(l, t)) begin n_err++; $display("FAIL run_count it=%0d L=%0d t=%0d got=%h exp=%h", it, l, t, v, exp_count(l, t)); end
            rd(ADDR_STATUS, v);
            n_cmp++; if (v !== 21'((nexp > 0) ? 1 : 0)) begin n_err++; $display("FAIL run_status it=%0d got=%h exp=%0d", it, v, (nexp > 0) ? 1 : 0); end
            n_cmp++; if (pulses - base != ep) begin n_err++; $display("FAIL run_pulses it=%0d got=%0d exp=%0d", it, pulses - base, ep); end
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] v;
        wr(ADDR_LOAD, 21'h00123);
        wr(ADDR_KICK, 21'h00005);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = ADDR_CTRL; PWRITE = 1'b1; PWDATA = 21'h1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        #1;
        n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL rstmid_pready got=%b exp=0", PREADY); end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        n_cmp++; if (PREADY !== 1'b0) begin n_err++; $display("FAIL rstmid_pready_hold got=%b exp=0", PREADY); end
        PRESET = 1'b0;
        rd(ADDR_CTRL, v);
        n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL rstmid_ctrl got=%h exp=0", v); end
        rd(ADDR_LOAD, v);
        n_cmp++; if (v !== LOAD_RST) begin n_err++; $display("FAIL rstmid_load got=%h exp=%h", v, LOAD_RST); end
        rd(ADDR_COUNT, v);
        n_cmp++; if (v !== LOAD_RST) begin n_err++; $display("FAIL rstmid_count got=%h exp=%h", v, LOAD_RST); end
        rd(ADDR_STATUS, v);
        n_cmp++; if (v !== 21'h0) begin n_err++; $display("FAIL rstmid_status got=%h exp=0", v); end
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        test_reset();
        test_wait_states();
        test_sticky_penable();
        test_regs_random();
        test_abort();
        test_expiry();
        test_kick();
        test_badkick();
        test_kick_vs_expiry();
        test_random_run();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
